// File: rtl/jt89_pkg.sv
// Shared definitions for the JT89 CPU register interface: register indices,
// field widths, the busy-timer state type and the tone-period update helper.
package jt89_pkg;

  localparam int unsigned TONE_W  = 10;
  localparam int unsigned VOL_W   = 4;
  localparam int unsigned NCTRL_W = 3;

  localparam logic [VOL_W-1:0] VOL_OFF = 4'hF;

  // Register index = {channel[1:0], type}; type 0 = tone/noise-ctrl, 1 = volume.
  localparam logic [2:0] REG_TONE0 = 3'd0;
  localparam logic [2:0] REG_VOL0  = 3'd1;
  localparam logic [2:0] REG_TONE1 = 3'd2;
  localparam logic [2:0] REG_VOL1  = 3'd3;
  localparam logic [2:0] REG_TONE2 = 3'd4;
  localparam logic [2:0] REG_VOL2  = 3'd5;
  localparam logic [2:0] REG_NOISE = 3'd6;
  localparam logic [2:0] REG_VOL3  = 3'd7;

  typedef enum logic {
    RT_IDLE,
    RT_BUSY
  } rt_state_t;

  // Latch bytes replace the low nibble of a tone period, data bytes the top six bits.
  function automatic logic [TONE_W-1:0] tone_next(input logic [TONE_W-1:0] cur,
                                                  input logic [7:0]        d);
    if (d[7]) return {cur[9:4], d[3:0]};
    else      return {d[5:0], cur[3:0]};
  endfunction

endpackage

// File: rtl/jt89_ready_timer.sv
// Busy timer behind the PSG READY output: after an accepted write, READY
// stays low for READY_CYCLES clk_en ticks.
module jt89_ready_timer
  import jt89_pkg::*;
#(
  parameter int unsigned READY_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_en,
  input  logic start,
  output logic ready
);

  localparam logic [7:0] LOAD = 8'(READY_CYCLES);

  rt_state_t  state;
  rt_state_t  state_next;
  logic [7:0] cnt;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= RT_IDLE;
    else     state <= state_next;
  end

  // Next-state logic: leave BUSY on the clk_en that takes the count to zero.
  always_comb begin
    state_next = state;
    case (state)
      RT_IDLE: if (start) state_next = RT_BUSY;
      RT_BUSY: if (clk_en && cnt == 8'd1) state_next = RT_IDLE;
      default: state_next = RT_IDLE;
    endcase
  end

  // Remaining-ticks counter; a clk_en in the accepting cycle is not counted.
  always_ff @(posedge clk) begin
    if (rst)                                cnt <= '0;
    else if (state == RT_IDLE && start)     cnt <= LOAD;
    else if (state == RT_BUSY && clk_en)    cnt <= cnt - 8'd1;
  end

  // Output decode.
  always_comb begin
    ready = (state == RT_IDLE);
  end

endmodule

// File: rtl/jt89_reg_if.sv
// JT89 PSG CPU register interface: decodes SN76489 latch/data writes into
// tone, attenuation and noise-control registers and models READY.
// Optional Game Gear stereo register: define JT89_GG_STEREO_EN.
module jt89_reg_if
  import jt89_pkg::*;
#(
  parameter int unsigned READY_CYCLES = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_en,
  input  logic               cs_n,
  input  logic               wr_n,
  input  logic [7:0]         din,
`ifdef JT89_GG_STEREO_EN
  input  logic               gg_n,
  output logic [7:0]         stereo,
`endif
  output logic               ready,
  output logic [TONE_W-1:0]  tone0,
  output logic [TONE_W-1:0]  tone1,
  output logic [TONE_W-1:0]  tone2,
  output logic [VOL_W-1:0]   vol0,
  output logic [VOL_W-1:0]   vol1,
  output logic [VOL_W-1:0]   vol2,
  output logic [VOL_W-1:0]   vol3,
  output logic [NCTRL_W-1:0] noise_ctrl,
  output logic               noise_rst
);

  logic       s;
  logic       s_d;
  logic       psg_wr;
  logic       start;
  logic [2:0] latch_reg;
  logic [2:0] reg_idx;

  assign s       = ~cs_n & ~wr_n;
  assign psg_wr  = s & ~s_d & ready;
  // Data bytes reuse the last latched register index.
  assign reg_idx = din[7] ? din[6:4] : latch_reg;

`ifdef JT89_GG_STEREO_EN
  logic g;
  logic g_d;
  logic gg_wr;

  assign g     = ~gg_n & ~wr_n;
  // An active PSG strobe takes priority over the stereo port.
  assign gg_wr = g & ~g_d & ready & ~s;
  assign start = psg_wr | gg_wr;

  // Stereo strobe edge detector and stereo register.
  always_ff @(posedge clk) begin
    if (rst) begin
      g_d    <= 1'b0;
      stereo <= 8'hFF;
    end else begin
      g_d <= g;
      if (gg_wr) stereo <= din;
    end
  end
`else
  assign start = psg_wr;
`endif

  // PSG strobe edge detector.
  always_ff @(posedge clk) begin
    if (rst) s_d <= 1'b0;
    else     s_d <= s;
  end

  // Register file update on accepted PSG writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      latch_reg  <= '0;
      tone0      <= '0;
      tone1      <= '0;
      tone2      <= '0;
      vol0       <= VOL_OFF;
      vol1       <= VOL_OFF;
      vol2       <= VOL_OFF;
      vol3       <= VOL_OFF;
      noise_ctrl <= '0;
      noise_rst  <= 1'b0;
    end else begin
      noise_rst <= 1'b0;
      if (psg_wr) begin
        if (din[7]) latch_reg <= din[6:4];
        case (reg_idx)
          REG_TONE0: tone0 <= tone_next(tone0, din);
          REG_TONE1: tone1 <= tone_next(tone1, din);
          REG_TONE2: tone2 <= tone_next(tone2, din);
          REG_VOL0:  vol0  <= din[3:0];
          REG_VOL1:  vol1  <= din[3:0];
          REG_VOL2:  vol2  <= din[3:0];
          REG_VOL3:  vol3  <= din[3:0];
          REG_NOISE: begin
            noise_ctrl <= din[2:0];
            noise_rst  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  jt89_ready_timer #(
    .READY_CYCLES(READY_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clk_en(clk_en),
    .start (start),
    .ready (ready)
  );

endmodule

// File: tb/tb_jt89_reg_if.sv
// Bench for jt89_reg_if: directed protocol cases plus randomized traffic,
// every cycle compared against a register-level reference model.
module tb_jt89_reg_if;

  localparam int unsigned RC    = 32;
  localparam int          LIMIT = 2000;

  logic       clk = 1'b0;
  logic       rst, clk_en, cs_n, wr_n;
  logic [7:0] din;
  logic       ready, noise_rst;
  logic [9:0] tone0, tone1, tone2;
  logic [3:0] vol0, vol1, vol2, vol3;
  logic [2:0] noise_ctrl;
`ifdef JT89_GG_STEREO_EN
  logic       gg_n;
  logic [7:0] stereo;
`endif

  always #5 clk = ~clk;

  jt89_reg_if #(.READY_CYCLES(RC)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .cs_n(cs_n), .wr_n(wr_n), .din(din),
`ifdef JT89_GG_STEREO_EN
    .gg_n(gg_n), .stereo(stereo),
`endif
    .ready(ready), .tone0(tone0), .tone1(tone1), .tone2(tone2),
    .vol0(vol0), .vol1(vol1), .vol2(vol2), .vol3(vol3),
    .noise_ctrl(noise_ctrl), .noise_rst(noise_rst)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: register contents and remaining busy ticks.
  logic [9:0] m_tone [3];
  logic [3:0] m_vol  [4];
  logic [2:0] m_nctrl, m_latch;
  logic       m_nrst, m_sd, m_valid = 1'b0;
  int         m_rem;
  logic [7:0] m_stereo;
  logic       m_gd;
  bit         en_rand = 0;

  task automatic model_step();
    logic s, acc, gacc;
    int   idx, ch;
    if (rst) begin
      for (int i = 0; i < 3; i++) m_tone[i] = '0;
      for (int i = 0; i < 4; i++) m_vol[i] = 4'hF;
      m_nctrl = 0; m_latch = 0; m_nrst = 0; m_sd = 0; m_rem = 0;
      m_stereo = 8'hFF; m_gd = 0; m_valid = 1;
      return;
    end
    s    = !cs_n && !wr_n;
    acc  = s && !m_sd && (m_rem == 0);
    gacc = 0;
`ifdef JT89_GG_STEREO_EN
    gacc = !gg_n && !wr_n && !m_gd && (m_rem == 0) && !s;
    if (gacc) m_stereo = din;
    m_gd = !gg_n && !wr_n;
`endif
    m_nrst = 0;
    if (acc) begin
      idx = din[7] ? int'(din[6:4]) : int'(m_latch);
      if (din[7]) m_latch = din[6:4];
      ch = idx / 2;
      if (idx % 2 == 1)  m_vol[ch] = din[3:0];
      else if (ch == 3) begin m_nctrl = din[2:0]; m_nrst = 1; end
      else if (din[7])   m_tone[ch] = (m_tone[ch] & 10'h3F0) | 10'(din[3:0]);
      else               m_tone[ch] = (10'(din[5:0]) << 4) | (m_tone[ch] & 10'h00F);
    end
    if (acc || gacc)                 m_rem = RC;
    else if (m_rem > 0 && clk_en)    m_rem = m_rem - 1;
    m_sd = s;
  endtask

  // One clock cycle: pick clk_en, compare on the falling edge, advance the model.
  task automatic cycle();
    logic [50:0] got, exp;
    clk_en = en_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk);
    if (m_valid) begin
      got = {ready, tone0, tone1, tone2, vol0, vol1, vol2, vol3, noise_ctrl, noise_rst};
      exp = {m_rem == 0, m_tone[0], m_tone[1], m_tone[2],
             m_vol[0], m_vol[1], m_vol[2], m_vol[3], m_nctrl, m_nrst};
      check("cycle_state", 64'(got), 64'(exp));
`ifdef JT89_GG_STEREO_EN
      check("cycle_stereo", 64'(stereo), 64'(m_stereo));
`endif
    end
    model_step();
    @(posedge clk);
    #1;
  endtask

  // Single strobe, then wait (bounded) for READY to return.
  task automatic psg_write(input logic [7:0] b, output int low, output logic nr1, output logic nr2);
    cs_n = 0; wr_n = 0; din = b;
    cycle();
    nr1 = noise_rst;
    cs_n = 1; wr_n = 1;
    cycle();
    nr2 = noise_rst;
    low = 1;
    while (!ready && low < LIMIT) begin
      cycle();
      low++;
    end
    if (low >= LIMIT) check("ready_timeout", 64'(ready), 64'(1));
  endtask

  int   low;
  logic nr1, nr2;

  initial begin
    rst = 1; cs_n = 1; wr_n = 1; din = 0; clk_en = 1;
`ifdef JT89_GG_STEREO_EN
    gg_n = 1;
`endif
    @(posedge clk); #1;
    repeat (3) cycle();
    rst = 0;

    check("rst_tone", 64'({tone0, tone1, tone2}), 64'(0));
    check("rst_vol", 64'({vol0, vol1, vol2, vol3}), 64'(16'hFFFF));
    check("rst_nctrl", 64'(noise_ctrl), 64'(0));
    check("rst_ready", 64'(ready), 64'(1));
    check("rst_nrst", 64'(noise_rst), 64'(0));
    cycle();

    // Two-byte tone write with clk_en constantly on.
    psg_write(8'h8E, low, nr1, nr2);
    check("busy_len_latch", 64'(low), 64'(RC));
    psg_write(8'h0F, low, nr1, nr2);
    check("busy_len_data", 64'(low), 64'(RC));
    check("tone0_two_byte", 64'(tone0), 64'(10'h0FE));

    // Noise register: latch byte, then data byte with the latch still on noise.
    psg_write(8'hE5, low, nr1, nr2);
    check("noise_latch", 64'(noise_ctrl), 64'(5));
    check("nrst_pulse1", 64'({nr1, nr2}), 64'(2'b10));
    psg_write(8'h03, low, nr1, nr2);
    check("noise_data", 64'(noise_ctrl), 64'(3));
    check("nrst_pulse2", 64'({nr1, nr2}), 64'(2'b10));

    // Volume, then a data byte issued in the first ready cycle.
    psg_write(8'h9A, low, nr1, nr2);
    check("vol0_latch", 64'(vol0), 64'(4'hA));
    psg_write(8'h1F, low, nr1, nr2);
    check("vol0_data", 64'(vol0), 64'(4'hF));
    check("tone0_kept", 64'(tone0), 64'(10'h0FE));
    check("busy_len_back2back", 64'(low), 64'(RC));

    // Edge while busy is dropped; a held strobe writes once.
    cs_n = 0; wr_n = 0; din = 8'hC1;
    cycle();
    cs_n = 1; wr_n = 1;
    cycle();
    cs_n = 0; wr_n = 0; din = 8'h80;
    repeat (100) cycle();
    check("tone2_low", 64'(tone2[3:0]), 64'(1));
    check("tone0_ignored", 64'(tone0), 64'(10'h0FE));
    check("held_one_write", 64'(ready), 64'(1));
    cs_n = 1; wr_n = 1;
    cycle();

    // Reset in the middle of a busy period.
    cs_n = 0; wr_n = 0; din = 8'h90;
    cycle();
    cs_n = 1; wr_n = 1;
    repeat (5) cycle();
    check("busy_before_rst", 64'(ready), 64'(0));
    rst = 1;
    cycle();
    rst = 0;
    check("rst_mid_ready", 64'(ready), 64'(1));
    check("rst_mid_vol", 64'({vol0, vol1, vol2, vol3}), 64'(16'hFFFF));
    cycle();

`ifdef JT89_GG_STEREO_EN
    gg_n = 0; wr_n = 0; din = 8'h5A;
    cycle();
    gg_n = 1; wr_n = 1;
    check("stereo_write", 64'(stereo), 64'(8'h5A));
    repeat (RC + 2) cycle();
    gg_n = 0; cs_n = 0; wr_n = 0; din = 8'h33;
    cycle();
    gg_n = 1; cs_n = 1; wr_n = 1;
    check("stereo_priority", 64'(stereo), 64'(8'h5A));
    repeat (RC + 2) cycle();
`endif

    // Randomized traffic with random clk_en and occasional resets.
    en_rand = 1;
    for (int i = 0; i < 4000; i++) begin
      cs_n = 1'($urandom_range(0, 2) == 0 ? 0 : 1);
      wr_n = 1'($urandom_range(0, 2) == 0 ? 0 : 1);
      din  = 8'($urandom);
      rst  = ($urandom_range(0, 499) == 0);
`ifdef JT89_GG_STEREO_EN
      gg_n = 1'($urandom_range(0, 3) == 0 ? 0 : 1);
`endif
      cycle();
    end
    rst = 0; cs_n = 1; wr_n = 1;
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
